// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver (optional parity check: PS2_RX_PARITY_CHECK_EN)
module ps2_rx #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   input  logic       i_spa,
   output logic       o_cap,
   output logic [7:0] o_dap,
   output logic       o_err,
   output logic       o_busy
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [SYNC_STAGES-1:0] r_csync;
   logic [SYNC_STAGES-1:0] r_dsync;
   logic [FW-1:0]          r_fcnt;
   logic                   r_fclk;
   state_t                 r_state;
   logic [2:0]             r_bit;
   logic [7:0]             r_sh;
   logic [TW-1:0]          r_to;
`ifdef PS2_RX_PARITY_CHECK_EN
   logic                   r_par;
`endif

   logic w_sclk;
   logic w_sdata;
   logic w_fall;
   logic w_frame_ok;

   assign w_sclk  = r_csync[SYNC_STAGES-1];
   assign w_sdata = r_dsync[SYNC_STAGES-1];
   // The filtered clock drops in exactly this cycle, so data is sampled alongside it.
   assign w_fall  = r_fclk && !w_sclk && (r_fcnt == FW'(FILTER_LEN - 1));

`ifdef PS2_RX_PARITY_CHECK_EN
   assign w_frame_ok = w_sdata && (^{r_sh, r_par});
`else
   assign w_frame_ok = w_sdata;
`endif

   assign o_busy = (r_state != S_IDLE);

   // Synchronisers; preset high so reset looks like an idle bus.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_csync <= '1;
         r_dsync <= '1;
      end else begin
         r_csync <= {r_csync[SYNC_STAGES-2:0], i_ps2_clk};
         r_dsync <= {r_dsync[SYNC_STAGES-2:0], i_ps2_data};
      end
   end

   // Glitch filter: the filtered clock follows only after FILTER_LEN differing samples in a row.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fclk <= 1'b1;
         r_fcnt <= '0;
      end else if (w_sclk == r_fclk) begin
         r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
         r_fclk <= w_sclk;
         r_fcnt <= '0;
      end else begin
         r_fcnt <= r_fcnt + 1'b1;
      end
   end

   // Frame FSM with timeout and registered strobes.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_bit   <= '0;
         r_sh    <= '0;
         r_to    <= '0;
         o_cap   <= 1'b0;
         o_err   <= 1'b0;
         o_dap   <= 8'h00;
`ifdef PS2_RX_PARITY_CHECK_EN
         r_par   <= 1'b0;
`endif
      end else begin
         o_cap <= 1'b0;
         o_err <= 1'b0;
         if (r_state == S_IDLE || w_fall) begin
            r_to <= '0;
         end else begin
            r_to <= r_to + 1'b1;
         end

         if (w_fall) begin
            case (r_state)
               S_IDLE: begin
                  if (!w_sdata) begin
                     r_state <= S_DATA;
                     r_bit   <= '0;
                  end
               end
               S_DATA: begin
                  r_sh <= {w_sdata, r_sh[7:1]};
                  if (r_bit == 3'd7) begin
                     r_state <= S_PARITY;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end
               S_PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
                  r_par <= w_sdata;
`endif
                  r_state <= S_STOP;
               end
               default: begin
                  if (!w_frame_ok) begin
                     o_err <= 1'b1;
                  end else if (i_spa) begin
                     o_cap <= 1'b1;
                     o_dap <= r_sh;
                  end
                  r_state <= S_IDLE;
               end
            endcase
         end else if (r_state != S_IDLE && r_to == TW'(TIMEOUT_CYCLES - 1)) begin
            // Line went quiet mid-frame: drop the partial byte.
            r_state <= S_IDLE;
            o_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - self-checking bench for ps2_rx
module tb_ps2_rx;

   localparam int HALF = 20;
   localparam int TO   = 500;
`ifdef PS2_RX_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_ps2_clk = 1'b1;
   logic       i_ps2_data = 1'b1;
   logic       i_spa = 1'b1;
   logic       o_cap;
   logic [7:0] o_dap;
   logic       o_err;
   logic       o_busy;

   int total = 0;
   int bad = 0;

   int cap_n = 0;
   int err_n = 0;
   int both_n = 0;
   int long_n = 0;
   logic prev_cap = 1'b0;
   logic prev_err = 1'b0;

   ps2_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_ps2_clk(i_ps2_clk), .i_ps2_data(i_ps2_data),
      .i_spa(i_spa), .o_cap(o_cap), .o_dap(o_dap), .o_err(o_err), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      cap_n    <= cap_n + (o_cap ? 1 : 0);
      err_n    <= err_n + (o_err ? 1 : 0);
      both_n   <= both_n + ((o_cap && o_err) ? 1 : 0);
      long_n   <= long_n + (((o_cap && prev_cap) || (o_err && prev_err)) ? 1 : 0);
      prev_cap <= o_cap;
      prev_err <= o_err;
   end

   typedef struct {
      logic [7:0] d;
      logic       pbad;
      logic       stop;
      logic       spa;
      int         ecap;
      int         eerr;
      logic [7:0] edap;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wcyc(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Drives the first nedges bits of a frame; a glitch lands in the high phase of bit 4.
   task automatic frame(input logic [7:0] d, input logic pbad, input logic stop,
                        input logic spa, input logic glitch, input int nedges);
      logic [10:0] f;
      logic        p;
      p = (($countones(d) % 2) == 0) ^ pbad;
      f = {stop, p, d, 1'b0};
      i_spa = spa;
      for (int i = 0; i < nedges; i++) begin
         i_ps2_data = f[i];
         if (glitch && i == 4) begin
            wcyc(6);
            i_ps2_clk = 1'b0;
            wcyc(2);
            i_ps2_clk = 1'b1;
            wcyc(HALF - 8);
         end else begin
            wcyc(HALF);
         end
         i_ps2_clk = 1'b0;
         wcyc(HALF);
         i_ps2_clk = 1'b1;
      end
      wcyc(HALF);
      i_ps2_data = 1'b1;
   endtask

   task automatic run_vec(input string tag, input vec_t v, input logic glitch);
      int c0, e0;
      c0 = cap_n;
      e0 = err_n;
      frame(v.d, v.pbad, v.stop, v.spa, glitch, 11);
      wcyc(2);
      chk({tag, "_cap"}, cap_n - c0, v.ecap);
      chk({tag, "_err"}, err_n - e0, v.eerr);
      chk({tag, "_dap"}, int'(o_dap), int'(v.edap));
      chk({tag, "_busy"}, int'(o_busy), 0);
   endtask

   vec_t tbl[7];
   logic [7:0] model_dap;

   initial begin
      int c0, e0;
      vec_t v;

      tbl[0] = '{8'h1D, 1'b0, 1'b1, 1'b1, 1, 0, 8'h1D};
      tbl[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1, 0, 8'hF0};
      tbl[2] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1, 0, 8'h1C};
      tbl[3] = '{8'h29, 1'b0, 1'b0, 1'b1, 0, 1, 8'h1C};
      tbl[4] = '{8'h76, 1'b0, 1'b1, 1'b1, 1, 0, 8'h76};
      tbl[5] = '{8'h1D, 1'b1, 1'b1, 1'b1, PCHK ? 0 : 1, PCHK ? 1 : 0, PCHK ? 8'h76 : 8'h1D};
      tbl[6] = '{8'h33, 1'b0, 1'b1, 1'b0, 0, 0, PCHK ? 8'h76 : 8'h1D};

      wcyc(5);
      chk("rst_cap", int'(o_cap), 0);
      chk("rst_err", int'(o_err), 0);
      chk("rst_dap", int'(o_dap), 0);
      chk("rst_busy", int'(o_busy), 0);
      i_rst = 1'b0;
      wcyc(10);

      for (int i = 0; i < 7; i++) run_vec($sformatf("tbl%0d", i), tbl[i], 1'b0);
      model_dap = tbl[6].edap;

      // Abandoned frame: start plus four data bits, then silence.
      c0 = cap_n;
      e0 = err_n;
      frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 5);
      chk("to_busy_mid", int'(o_busy), 1);
      wcyc(TO + 20);
      chk("to_err", err_n - e0, 1);
      chk("to_cap", cap_n - c0, 0);
      chk("to_busy", int'(o_busy), 0);
      chk("to_dap", int'(o_dap), int'(model_dap));
      v = '{8'h12, 1'b0, 1'b1, 1'b1, 1, 0, 8'h12};
      run_vec("after_to", v, 1'b0);

      // Short low pulse with data low while idle must not look like a start bit.
      e0 = err_n;
      i_ps2_data = 1'b0;
      i_ps2_clk = 1'b0;
      wcyc(2);
      i_ps2_clk = 1'b1;
      wcyc(10);
      i_ps2_data = 1'b1;
      chk("glitch_idle_busy", int'(o_busy), 0);
      wcyc(TO + 20);
      chk("glitch_idle_err", err_n - e0, 0);
      v = '{8'h14, 1'b0, 1'b1, 1'b1, 1, 0, 8'h14};
      run_vec("glitch_mid", v, 1'b1);
      model_dap = 8'h14;

      // Randomised frames against a rule-level model.
      for (int i = 0; i < 20; i++) begin
         logic good;
         v.d    = 8'($urandom);
         v.pbad = ($urandom % 5) == 0;
         v.stop = ($urandom % 5) != 0;
         v.spa  = ($urandom % 4) != 0;
         good   = v.stop && !(PCHK && v.pbad);
         v.ecap = (good && v.spa) ? 1 : 0;
         v.eerr = good ? 0 : 1;
         if (v.ecap == 1) model_dap = v.d;
         v.edap = model_dap;
         run_vec($sformatf("rnd%0d", i), v, 1'b0);
      end

      // Reset in the middle of a frame: frame dropped, no strobe.
      c0 = cap_n;
      e0 = err_n;
      frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 6);
      i_rst = 1'b1;
      wcyc(3);
      i_rst = 1'b0;
      wcyc(TO + 20);
      chk("mrst_busy", int'(o_busy), 0);
      chk("mrst_dap", int'(o_dap), 0);
      chk("mrst_strobes", (cap_n - c0) + (err_n - e0), 0);
      v = '{8'h5A, 1'b0, 1'b1, 1'b1, 1, 0, 8'h5A};
      run_vec("after_mrst", v, 1'b0);

      chk("cap_err_overlap", both_n, 0);
      chk("strobe_width", long_n, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
